// File: rtl/atri_pps_holdover_ctrl.sv
// PPS discipline / holdover controller with a one-deep PPS-aligned event scheduler.
// Holdover pulse synthesis is built only when ATRI_PPS_HOLDOVER_EN is defined.
module atri_pps_holdover_ctrl #(
    parameter int PERIOD_MS = 1000,
    parameter int GUARD_MS  = 5
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        pps_flag_i,
    input  logic        KHz_CE_i,
    input  logic [31:0] sched_sec_i,
    input  logic        sched_valid_i,
    output logic        sched_ready_o,
    output logic        pps_flag_o,
    output logic        sched_fire_o,
    output logic [31:0] sec_count_o,
    output logic [9:0]  ms_count_o,
    output logic [1:0]  state_o,
    output logic [15:0] missed_o
);

    typedef enum logic [1:0] {
        ST_ACQUIRE  = 2'd0,
        ST_LOCKED   = 2'd1,
        ST_HOLDOVER = 2'd2
    } state_t;

    localparam logic [9:0] LOCK_LIM = 10'(PERIOD_MS + GUARD_MS);
`ifdef ATRI_PPS_HOLDOVER_EN
    localparam logic [9:0] HOLD_LIM = 10'(PERIOD_MS);
`endif

    state_t      state;
    state_t      state_next;
    logic [9:0]  ms_tick;
    logic [9:0]  ms_next;
    logic        pulse_next;
    logic        miss_next;
    logic        fire_next;
    logic        sched_pending;
    logic [31:0] sched_target;
    logic [31:0] sec_inc;
    logic        sched_accept;
    logic        lock_timeout;
`ifdef ATRI_PPS_HOLDOVER_EN
    logic        hold_timeout;
`endif

    // Scheduler handshake: a request transfers on any rising edge where
    // sched_valid_i and sched_ready_o are both high; ready stays low from the
    // cycle after acceptance through the cycle in which sched_fire_o is high.
    assign sched_ready_o = ~sched_pending;
    assign sched_accept  = sched_valid_i & ~sched_pending;
    assign state_o       = state;
    assign sec_inc       = sec_count_o + 32'd1;

    assign ms_tick      = (ms_count_o == 10'h3FF) ? ms_count_o : ms_count_o + 10'd1;
    assign lock_timeout = KHz_CE_i && (ms_tick == LOCK_LIM) && (ms_count_o != LOCK_LIM);
`ifdef ATRI_PPS_HOLDOVER_EN
    assign hold_timeout = KHz_CE_i && (ms_tick == HOLD_LIM) && (ms_count_o != HOLD_LIM);
`endif

    always_comb begin
        state_next = state;
        ms_next    = ms_count_o;
        pulse_next = 1'b0;
        miss_next  = 1'b0;
        case (state)
            ST_ACQUIRE: begin
                ms_next = 10'd0;
                if (pps_flag_i) begin
                    pulse_next = 1'b1;
                    state_next = ST_LOCKED;
                end
            end
            ST_LOCKED: begin
                // A real PPS always wins, early or coincident with a tick.
                if (pps_flag_i) begin
                    pulse_next = 1'b1;
                    ms_next    = 10'd0;
                end else if (lock_timeout) begin
                    miss_next = 1'b1;
                    ms_next   = 10'd0;
`ifdef ATRI_PPS_HOLDOVER_EN
                    pulse_next = 1'b1;
                    state_next = ST_HOLDOVER;
`endif
                end else if (KHz_CE_i) begin
                    ms_next = ms_tick;
                end
            end
            ST_HOLDOVER: begin
`ifdef ATRI_PPS_HOLDOVER_EN
                // A real PPS replaces the synthetic one, never adds to it.
                if (pps_flag_i) begin
                    pulse_next = 1'b1;
                    ms_next    = 10'd0;
                    state_next = ST_LOCKED;
                end else if (hold_timeout) begin
                    pulse_next = 1'b1;
                    miss_next  = 1'b1;
                    ms_next    = 10'd0;
                end else if (KHz_CE_i) begin
                    ms_next = ms_tick;
                end
`else
                state_next = ST_ACQUIRE;
                ms_next    = 10'd0;
`endif
            end
            default: begin
                state_next = ST_ACQUIRE;
                ms_next    = 10'd0;
            end
        endcase
        // Only a request already pending before this pulse is evaluated.
        fire_next = pulse_next && sched_pending && !sched_fire_o && (sec_inc >= sched_target);
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state         <= ST_ACQUIRE;
            ms_count_o    <= 10'd0;
            sec_count_o   <= 32'd0;
            missed_o      <= 16'd0;
            pps_flag_o    <= 1'b0;
            sched_fire_o  <= 1'b0;
            sched_pending <= 1'b0;
            sched_target  <= 32'd0;
        end else begin
            state        <= state_next;
            ms_count_o   <= ms_next;
            pps_flag_o   <= pulse_next;
            sched_fire_o <= fire_next;
            if (pulse_next) begin
                sec_count_o <= sec_inc;
            end
            if (miss_next && (missed_o != 16'hFFFF)) begin
                missed_o <= missed_o + 16'd1;
            end
            if (sched_fire_o) begin
                sched_pending <= 1'b0;
            end else if (sched_accept) begin
                sched_pending <= 1'b1;
                sched_target  <= sched_sec_i;
            end
        end
    end

endmodule

// File: tb/tb_atri_pps_holdover_ctrl.sv
// Bench for atri_pps_holdover_ctrl: directed scenarios plus random traffic,
// checked every cycle against a tick-counting reference model.
module tb_atri_pps_holdover_ctrl;

    localparam int PERIOD = 1000;
    localparam int GUARD  = 5;

    logic        clk_i = 1'b0;
    logic        rst_n_i = 1'b0;
    logic        pps_flag_i = 1'b0;
    logic        KHz_CE_i = 1'b0;
    logic [31:0] sched_sec_i = 32'd0;
    logic        sched_valid_i = 1'b0;
    logic        sched_ready_o;
    logic        pps_flag_o;
    logic        sched_fire_o;
    logic [31:0] sec_count_o;
    logic [9:0]  ms_count_o;
    logic [1:0]  state_o;
    logic [15:0] missed_o;

    int n_vec = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    atri_pps_holdover_ctrl dut (
        .clk_i        (clk_i),
        .rst_n_i      (rst_n_i),
        .pps_flag_i   (pps_flag_i),
        .KHz_CE_i     (KHz_CE_i),
        .sched_sec_i  (sched_sec_i),
        .sched_valid_i(sched_valid_i),
        .sched_ready_o(sched_ready_o),
        .pps_flag_o   (pps_flag_o),
        .sched_fire_o (sched_fire_o),
        .sec_count_o  (sec_count_o),
        .ms_count_o   (ms_count_o),
        .state_o      (state_o),
        .missed_o     (missed_o)
    );

    // clock / reset
    always #5 clk_i = ~clk_i;

    // reference model: mode 0/1/2 = acquire/locked/holdover, ticks since last pulse
    int          m_mode = 0;
    int          m_ticks = 0;
    logic [31:0] m_sec = 32'd0;
    int          m_missed = 0;
    bit          m_pulse = 1'b0;
    bit          m_fire = 1'b0;
    logic [31:0] exp_q[$];
    bit          mr_ready, mr_pulse, mr_fire;
    int          mr_lim;

    always @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            m_mode = 0; m_ticks = 0; m_sec = 32'd0; m_missed = 0;
            m_pulse = 1'b0; m_fire = 1'b0;
            exp_q.delete();
        end else begin
            mr_ready = (exp_q.size() == 0);
            mr_pulse = 1'b0;
            if (pps_flag_i) begin
                mr_pulse = 1'b1;
                m_mode   = 1;
                m_ticks  = 0;
            end else if (m_mode != 0 && KHz_CE_i) begin
                m_ticks++;
                mr_lim = (m_mode == 1) ? PERIOD + GUARD : PERIOD;
                if (m_ticks == mr_lim) begin
                    m_ticks = 0;
                    if (m_missed < 65535) m_missed++;
`ifdef ATRI_PPS_HOLDOVER_EN
                    mr_pulse = 1'b1;
                    m_mode   = 2;
`endif
                end
            end
            mr_fire = mr_pulse && !m_fire && (exp_q.size() > 0) && ((m_sec + 32'd1) >= exp_q[0]);
            if (m_fire) void'(exp_q.pop_front());
            if (sched_valid_i && mr_ready) exp_q.push_back(sched_sec_i);
            if (mr_pulse) m_sec = m_sec + 32'd1;
            m_pulse = mr_pulse;
            m_fire  = mr_fire;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    // scoreboard: every cycle, away from the active edge
    always @(negedge clk_i) begin
        if (chk_en) begin
            check("pps_flag_o", 32'(pps_flag_o), 32'(m_pulse));
            check("sched_fire_o", 32'(sched_fire_o), 32'(m_fire));
            check("sched_ready_o", 32'(sched_ready_o), 32'(exp_q.size() == 0));
            check("sec_count_o", sec_count_o, m_sec);
            check("ms_count_o", 32'(ms_count_o), 32'((m_ticks > 1023) ? 1023 : m_ticks));
            check("state_o", 32'(state_o), 32'(m_mode));
            check("missed_o", 32'(missed_o), 32'(m_missed));
        end
    end

    // driver: apply inputs, advance one edge, return at edge+1
    task automatic step(input bit p, input bit k, input bit v, input logic [31:0] s);
        pps_flag_i    = p;
        KHz_CE_i      = k;
        sched_valid_i = v;
        sched_sec_i   = s;
        @(posedge clk_i);
        #1;
    endtask

    int cnt;

    initial begin
        repeat (3) @(posedge clk_i);
        #1;
        chk_en = 1'b1;
        check("rst_state", 32'(state_o), 32'd0);
        check("rst_ready", 32'(sched_ready_o), 32'd1);
        check("rst_sec", sec_count_o, 32'd0);
        rst_n_i = 1'b1;
        step(0, 0, 0, 0);
        check("rel_no_pulse", 32'(pps_flag_o), 32'd0);

        // acquire ignores ticks, then scenario 1
        repeat (5) step(0, 1, 0, 0);
        check("acq_ms_hold", 32'(ms_count_o), 32'd0);
        step(1, 0, 0, 0);
        check("s1_first_pps", 32'(pps_flag_o), 32'd1);
        check("s1_locked", 32'(state_o), 32'd1);
        repeat (999) step(0, 1, 0, 0);
        check("s1_ms999", 32'(ms_count_o), 32'd999);
        step(1, 1, 0, 0);
        check("s1_second_pps", 32'(pps_flag_o), 32'd1);
        check("s1_ms_clear", 32'(ms_count_o), 32'd0);
        check("s1_sec2", sec_count_o, 32'd2);

        // early pulses, no miss
        repeat (3) begin
            repeat (10) step(0, 1, 0, 0);
            step(1, 0, 0, 0);
        end
        check("early_sec5", sec_count_o, 32'd5);
        check("early_no_miss", 32'(missed_o), 32'd0);

        // scenario 4
        step(0, 0, 1, 32'd7);
        check("s4_ready_low", 32'(sched_ready_o), 32'd0);
        repeat (2) step(0, 0, 0, 0);
        step(1, 0, 0, 0);
        check("s4_no_fire_at6", 32'(sched_fire_o), 32'd0);
        repeat (5) step(0, 1, 0, 0);
        step(1, 0, 0, 0);
        check("s4_fire_at7", 32'(sched_fire_o), 32'd1);
        check("s4_sec7", sec_count_o, 32'd7);
        step(0, 0, 0, 0);
        check("s4_ready_back", 32'(sched_ready_o), 32'd1);

        // scenario 5: past target fires on next pulse
        step(0, 0, 1, 32'd3);
        step(0, 1, 0, 0);
        step(1, 0, 0, 0);
        check("s5_fire", 32'(sched_fire_o), 32'd1);

        // request accepted during a pulse cycle waits for the following pulse
        step(0, 0, 0, 0);
        step(1, 0, 0, 0);
        step(0, 0, 1, 32'd0);
        check("acc_on_pulse_nofire", 32'(sched_fire_o), 32'd0);
        step(1, 0, 0, 0);
        check("acc_on_pulse_fire", 32'(sched_fire_o), 32'd1);
        step(0, 0, 0, 0);

        // scenario 2 / timeout
        step(1, 0, 0, 0);
        cnt = 0;
`ifdef ATRI_PPS_HOLDOVER_EN
        do begin step(0, 1, 0, 0); cnt++; end while (!pps_flag_o && cnt < 1100);
        check("s2_gap1005", 32'(cnt), 32'd1005);
        check("s2_missed1", 32'(missed_o), 32'd1);
        check("s2_holdover", 32'(state_o), 32'd2);
        cnt = 0;
        do begin step(0, 1, 0, 0); cnt++; end while (!pps_flag_o && cnt < 1100);
        check("s2_gap1000", 32'(cnt), 32'd1000);
        check("s2_missed2", 32'(missed_o), 32'd2);
        // scenario 3
        repeat (700) step(0, 1, 0, 0);
        check("s3_ms700", 32'(ms_count_o), 32'd700);
        step(1, 0, 0, 0);
        check("s3_pulse", 32'(pps_flag_o), 32'd1);
        check("s3_ms0", 32'(ms_count_o), 32'd0);
        check("s3_locked", 32'(state_o), 32'd1);
        step(0, 0, 0, 0);
        check("s3_single", 32'(pps_flag_o), 32'd0);
        // reach holdover again for scenario 6
        step(0, 0, 1, 32'hFFFF_0000);
        repeat (1010) step(0, 1, 0, 0);
        check("s6_in_holdover", 32'(state_o), 32'd2);
`else
        repeat (1005) begin step(0, 1, 0, 0); cnt += int'(pps_flag_o); end
        check("to_no_synth", 32'(cnt), 32'd0);
        check("to_missed1", 32'(missed_o), 32'd1);
        check("to_ms0", 32'(ms_count_o), 32'd0);
        check("to_locked", 32'(state_o), 32'd1);
        step(0, 0, 1, 32'hFFFF_0000);
        repeat (20) step(0, 1, 0, 0);
`endif
        check("s6_pending", 32'(sched_ready_o), 32'd0);
        #2 rst_n_i = 1'b0;
        #1;
        check("s6_state", 32'(state_o), 32'd0);
        check("s6_ready", 32'(sched_ready_o), 32'd1);
        check("s6_sec", sec_count_o, 32'd0);
        check("s6_missed", 32'(missed_o), 32'd0);
        check("s6_ms", 32'(ms_count_o), 32'd0);
        @(posedge clk_i);
        #1;
        step(0, 0, 0, 0);
        rst_n_i = 1'b1;
        step(0, 0, 0, 0);

        // random traffic
        for (int i = 0; i < 12000; i++) begin
            if (i == 6000) begin
                rst_n_i = 1'b0;
                step(0, 0, 0, 0);
                rst_n_i = 1'b1;
            end
            step(($urandom_range(0, 699) == 0) || (i % 1500 == 1499 && $urandom_range(0, 1) == 1),
                 ($urandom_range(0, 3) != 0),
                 ($urandom_range(0, 15) == 0),
                 m_sec + 32'($urandom_range(0, 3)) - 32'd1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/atri_pps_holdover_ctrl.md
ATRI_PPS_HOLDOVER_CTRL -- requirements
Module: atri_pps_holdover_ctrl

Interface
REQ-001 Parameter PERIOD_MS, default 1000, KHz_CE_i ticks per nominal second.
REQ-002 Parameter GUARD_MS, default 5, extra ticks allowed past PERIOD_MS before a PPS is declared missing.
REQ-003 clk_i  input  1  sole clock; every register in the block is clocked on its rising edge.
REQ-004 rst_n_i  input  1  asynchronous active-low reset.
REQ-005 pps_flag_i  input  1  single-cycle debounced PPS flag, synchronous to clk_i.
REQ-006 KHz_CE_i  input  1  single-cycle 1 kHz clock enable.
REQ-007 sched_sec_i  input  32  target second for a scheduled event.
REQ-008 sched_valid_i  input  1  schedule request valid.
REQ-009 sched_ready_o  output  1  high when no schedule request is pending.
REQ-010 pps_flag_o  output  1  single-cycle PPS output; real or synthetic.
REQ-011 sched_fire_o  output  1  single-cycle scheduled-event strobe.
REQ-012 sec_count_o  output  32  seconds counter.
REQ-013 ms_count_o  output  10  KHz ticks since the last pps_flag_o.
REQ-014 state_o  output  2  ACQUIRE=0, LOCKED=1, HOLDOVER=2.
REQ-015 missed_o  output  16  missing-PPS count; saturates at 0xFFFF.

Function
REQ-016 The state machine SHALL have three states: ACQUIRE, LOCKED and HOLDOVER.
REQ-017 In ACQUIRE, ms_count SHALL hold at 0; a pps_flag_i pulse SHALL move the block to LOCKED and assert pps_flag_o.
REQ-018 pps_flag_o SHALL assert exactly one clk_i cycle after any pps_flag_i pulse accepted in LOCKED or HOLDOVER.
REQ-019 Outside ACQUIRE, ms_count SHALL increment on each KHz_CE_i tick, saturate at 1023, and clear to 0 in the cycle pps_flag_o is asserted.
REQ-020 If pps_flag_i and KHz_CE_i coincide, the PPS SHALL take priority and ms_count SHALL clear to 0.
REQ-021 In LOCKED, when ms_count reaches PERIOD_MS+GUARD_MS without a pps_flag_i pulse, the block SHALL increment missed_o, assert a synthetic pps_flag_o and move to HOLDOVER.
REQ-022 In HOLDOVER, the block SHALL assert a synthetic pps_flag_o and increment missed_o each time ms_count reaches PERIOD_MS.
REQ-023 A pps_flag_i pulse in HOLDOVER SHALL return the block to LOCKED and take the place of the synthetic pulse, so that no double pulse occurs.
REQ-024 A pps_flag_i pulse in LOCKED arriving before PERIOD_MS ticks SHALL still be accepted (early PPS), with no error count.
REQ-025 sec_count SHALL increment by 1 on every pps_flag_o and wrap modulo 2^32.
REQ-026 A schedule request SHALL be accepted when sched_valid_i and sched_ready_o are both high; sched_sec_i SHALL be latched and sched_ready_o SHALL drop in the next cycle.
REQ-027 sched_fire_o SHALL assert in the same cycle as the first pps_flag_o whose post-increment sec_count is greater than or equal to the target, compared unsigned; sched_ready_o SHALL reassert in the following cycle.
REQ-028 A request accepted in the same cycle as a pps_flag_o SHALL NOT be evaluated against that pulse.

Reset
REQ-029 When rst_n_i is low, the block SHALL enter ACQUIRE and set all counters, pps_flag_o and sched_fire_o to 0, and set sched_ready_o to 1; any pending schedule request SHALL be discarded.
REQ-030 Reset assertion SHALL take effect asynchronously; release SHALL be synchronous to clk_i, and no output pulse SHALL occur in the first cycle after release.

Configuration
REQ-031 The macro ATRI_PPS_HOLDOVER_EN SHALL control holdover.
REQ-032 With ATRI_PPS_HOLDOVER_EN defined, the block SHALL behave as REQ-021 to REQ-023.
REQ-033 Without ATRI_PPS_HOLDOVER_EN, no synthetic PPS SHALL be generated and HOLDOVER SHALL be unreachable.
REQ-034 Without ATRI_PPS_HOLDOVER_EN, on timeout missed_o SHALL increment, ms_count SHALL clear to 0 and the block SHALL stay in LOCKED.

Verification
REQ-035 Scenario 1: reset, then pps_flag_i at T and again 1000 KHz ticks later -> state_o=1; pps_flag_o at T+1 and at the second pulse+1; sec_count_o=2.
REQ-036 Scenario 2: in LOCKED, stop pps_flag_i -> synthetic pps_flag_o at tick 1005, then at every further 1000 ticks; missed_o=1, then 2, ...; state_o=2.
REQ-037 Scenario 3: in HOLDOVER, pps_flag_i at ms_count=700 -> exactly one pps_flag_o; ms_count_o=0; state_o=1.
REQ-038 Scenario 4: sec_count_o=5, schedule sched_sec_i=7 -> sched_ready_o=0; sched_fire_o with the pps_flag_o that sets sec_count_o=7; ready reasserts the next cycle.
REQ-039 Scenario 5: schedule sched_sec_i=3 while sec_count_o=5 -> sched_fire_o on the next pps_flag_o.
REQ-040 Scenario 6: rst_n_i low mid-HOLDOVER with a request pending -> all outputs at reset values within the same cycle; sched_ready_o=1.
